// File: rtl/down_count_monitor.sv
// Checks that a sampled count steps down by one each accepted sample.
// Reports zero and wrap events, counts wraps, and locks onto or flags errors in the stream.
module down_count_monitor #(
    parameter int WIDTH     = 4,
    parameter int WRAP_W    = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              clear,
    output logic              locked,
    output logic              err,
    output logic              zero_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count
);

    typedef enum logic [1:0] {IDLE, SYNC, TRACK, ERROR} state_t;

    localparam logic [3:0]        LP_ERR_LIMIT = 4'(ERR_LIMIT);
    localparam logic [WIDTH-1:0]  LP_ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WRAP_W-1:0] LP_WRAP_MAX  = {WRAP_W{1'b1}};

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_prev, w_prev_nxt;
    logic [3:0]        r_miss, w_miss_nxt;
    logic              r_zero, w_zero_nxt;
    logic              r_wrap, w_wrap_nxt;
    logic [WRAP_W-1:0] r_wrap_cnt, w_wrap_cnt_nxt;

    logic [WIDTH-1:0]  w_expect;
    logic [3:0]        w_miss_inc;
    logic              w_match;

    assign w_expect   = r_prev - WIDTH'(1);
    assign w_match    = (count_in == w_expect);
    assign w_miss_inc = r_miss + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            r_miss     <= '0;
            r_zero     <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_miss     <= w_miss_nxt;
            r_zero     <= w_zero_nxt;
            r_wrap     <= w_wrap_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev;
        w_miss_nxt     = r_miss;
        w_zero_nxt     = 1'b0;
        w_wrap_nxt     = 1'b0;
        w_wrap_cnt_nxt = r_wrap_cnt;

        // clear wins over a same-cycle sample, which is dropped
        if (clear) begin
            w_state_nxt    = IDLE;
            w_prev_nxt     = '0;
            w_miss_nxt     = '0;
            w_wrap_cnt_nxt = '0;
        end else if (en && r_state != ERROR) begin
            w_prev_nxt = count_in;
            w_zero_nxt = (count_in == '0);
            case (r_state)
                IDLE: w_state_nxt = SYNC;
                SYNC: begin
                    if (w_match) begin
                        w_state_nxt = TRACK;
                        w_miss_nxt  = '0;
                    end
                end
                TRACK: begin
                    if (w_match) begin
                        w_miss_nxt = '0;
                        if (r_prev == '0 && count_in == LP_ALL_ONES) begin
                            w_wrap_nxt = 1'b1;
                            if (r_wrap_cnt != LP_WRAP_MAX)
                                w_wrap_cnt_nxt = r_wrap_cnt + 1'b1;
                        end
                    end else begin
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == LP_ERR_LIMIT)
                            w_state_nxt = ERROR;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign locked     = (r_state == TRACK);
    assign err        = (r_state == ERROR);
    assign zero_pulse = r_zero;
    assign wrap_pulse = r_wrap;
    assign wrap_count = r_wrap_cnt;

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: vector table, hand-written corner sequences,
// then randomized streams checked against a reference model.
module tb_down_count_monitor;

    localparam int W      = 4;
    localparam int WW     = 2;
    localparam int ELIM   = 3;
    localparam int WC_MAX = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [W-1:0]  count_in;
    logic          clear;
    logic          locked, err, zero_pulse, wrap_pulse;
    logic [WW-1:0] wrap_count;

    int n_chk = 0;
    int n_err = 0;

    down_count_monitor #(.WIDTH(W), .WRAP_W(WW), .ERR_LIMIT(ELIM)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in), .clear(clear),
        .locked(locked), .err(err), .zero_pulse(zero_pulse),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en; bit clr; int cnt;
        bit lk; bit er; bit zp; bit wp; int wc;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit e, bit c, int v, bit lk, bit er, bit zp, bit wp, int wc);
        vec_t t;
        t.en = e; t.clr = c; t.cnt = v;
        t.lk = lk; t.er = er; t.zp = zp; t.wp = wp; t.wc = wc;
        tbl.push_back(t);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, bit lk, bit er, bit zp, bit wp, int wc);
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".err"}, 32'(err), 32'(er));
        chk({tag, ".zero_pulse"}, 32'(zero_pulse), 32'(zp));
        chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
        chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(wc));
    endtask

    // Inputs change 1 time unit after the active edge; outputs are read there too.
    task automatic step(bit e, bit c, int v);
        en = e; clear = c; count_in = W'(v);
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase 0=idle 1=sync 2=track 3=error
    int m_ph, m_prev, m_miss, m_wc;
    bit m_zp, m_wp;

    function automatic void model_reset();
        m_ph = 0; m_prev = 0; m_miss = 0; m_wc = 0; m_zp = 0; m_wp = 0;
    endfunction

    function automatic void model_step(bit e, bit c, int v);
        bit ok;
        m_zp = 0; m_wp = 0;
        if (c) begin
            m_ph = 0; m_prev = 0; m_miss = 0; m_wc = 0;
        end else if (e && m_ph != 3) begin
            ok = (v == (m_prev + (1 << W) - 1) % (1 << W));
            m_zp = (v == 0);
            if (m_ph == 0) m_ph = 1;
            else if (m_ph == 1) begin
                if (ok) begin m_ph = 2; m_miss = 0; end
            end else begin
                if (ok) begin
                    m_miss = 0;
                    if (m_prev == 0) begin
                        m_wp = 1;
                        if (m_wc < WC_MAX) m_wc++;
                    end
                end else begin
                    m_miss++;
                    if (m_miss == ELIM) m_ph = 3;
                end
            end
            m_prev = v;
        end
    endfunction

    initial begin
        int g, r;
        bit e, c;

        reset = 1'b1; en = 1'b0; clear = 1'b0; count_in = '0;
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Full descent with wrap, en toggling, glitch, stuck, clear recovery
        add(1, 0, 15, 0, 0, 0, 0, 0);
        add(1, 0, 14, 1, 0, 0, 0, 0);
        for (int v = 13; v >= 1; v--) add(1, 0, v, 1, 0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 1, 0, 0);
        add(1, 0, 15, 1, 0, 0, 1, 1);
        add(0, 0, 15, 1, 0, 0, 0, 1);
        add(1, 0, 14, 1, 0, 0, 0, 1);
        add(0, 0, 14, 1, 0, 0, 0, 1);
        add(1, 0, 13, 1, 0, 0, 0, 1);
        add(1, 0, 12, 1, 0, 0, 0, 1);
        add(1, 0, 11, 1, 0, 0, 0, 1);
        add(1, 0, 10, 1, 0, 0, 0, 1);
        add(1, 0, 9,  1, 0, 0, 0, 1);
        add(1, 0, 8,  1, 0, 0, 0, 1);
        add(1, 0, 3,  1, 0, 0, 0, 1);
        add(1, 0, 6,  1, 0, 0, 0, 1);
        add(1, 0, 5,  1, 0, 0, 0, 1);
        add(1, 0, 5,  1, 0, 0, 0, 1);
        add(1, 0, 5,  1, 0, 0, 0, 1);
        add(1, 0, 5,  0, 1, 0, 0, 1);
        add(1, 0, 4,  0, 1, 0, 0, 1);
        add(0, 0, 4,  0, 1, 0, 0, 1);
        add(1, 1, 7,  0, 0, 0, 0, 0);
        add(1, 0, 6,  0, 0, 0, 0, 0);
        add(1, 0, 5,  1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].cnt);
            chk_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].zp, tbl[i].wp, tbl[i].wc);
        end

        // 0 -> F on entry to TRACK is not a wrap; SYNC mismatch re-syncs
        step(1, 1, 0);
        step(1, 0, 0);
        chk_all("sync0", 0, 0, 1, 0, 0);
        step(1, 0, 15);
        chk_all("syncF", 1, 0, 0, 0, 0);
        step(1, 1, 3);
        step(1, 0, 3);
        step(1, 0, 9);
        chk_all("sync_miss", 0, 0, 0, 0, 0);
        step(1, 0, 8);
        chk_all("resync", 1, 0, 0, 0, 0);

        // Five wraps saturate a 2-bit wrap counter
        step(1, 1, 0);
        for (int k = 0; k < 5; k++)
            for (int v = 15; v >= 0; v--) step(1, 0, v);
        step(1, 0, 15);
        chk_all("sat", 1, 0, 0, 1, WC_MAX);

        // Asynchronous reset between edges
        step(1, 0, 14);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomized stream against the model
        model_reset();
        g = 15;
        for (int n = 0; n < 1500; n++) begin
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 39) == 0);
            if (e) begin
                r = $urandom_range(0, 99);
                if (r < 85) g = (g + 15) % 16;
                else if (r >= 93) g = $urandom_range(0, 15);
            end
            model_step(e, c, g);
            step(e, c, g);
            chk_all($sformatf("rnd%0d", n), (m_ph == 2), (m_ph == 3), m_zp, m_wp, m_wc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
